sync_edge_det: RTL and testbench

- Brings one asynchronous single-bit input into the clk domain through a multi-flop synchronizer, then flags transitions on the synchronized value.
- Output is a one-clock pulse per detected edge. Intended for pushbuttons and external strobes feeding control FSMs.
- The default configuration is a 2-flop synchronizer with rising-edge detection.

---
 rtl/sync_edge_pkg.sv | 35 +++
 rtl/sync_ff_chain.sv | 37 +++
 rtl/sync_edge_det.sv | 56 +++++
 tb/tb_sync_edge_det.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_edge_pkg.sv
// Shared types and limits for the single-bit synchronizer and edge detector.
package sync_edge_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_t;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  function automatic bit sync_stages_legal(input int n);
    return (n >= MIN_SYNC_STAGES) && (n <= MAX_SYNC_STAGES);
  endfunction

  function automatic bit edge_mode_legal(input edge_mode_t mode);
    return (mode == EDGE_RISE) || (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  endfunction

  // cur is the newest synchronized sample, prv the one before it.
  function automatic logic edge_detect(input edge_mode_t mode, input logic cur,
                                       input logic prv);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = cur & ~prv;
      EDGE_FALL: hit = ~cur & prv;
      EDGE_BOTH: hit = cur ^ prv;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for one asynchronous bit; reusable for any single-bit CDC input.
module sync_ff_chain
  import sync_edge_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $fatal(1, "sync_ff_chain: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  // Pure shift: sync_q[0] may be metastable and feeds only sync_q[1].
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous bit into clk and emits a one-cycle pulse per selected edge.
module sync_edge_det
  import sync_edge_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter edge_mode_t EDGE_MODE   = EDGE_RISE,
  parameter logic       RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic edge_det
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $fatal(1, "sync_edge_det: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end

  if (!edge_mode_legal(EDGE_MODE)) begin : g_bad_mode
    $fatal(1, "sync_edge_det: unsupported EDGE_MODE");
  end

  logic sync_out;
  logic prev_d;
  logic prev_q;

  sync_ff_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_chain (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (async_in),
    .q     (sync_out)
  );

  always_comb begin
    prev_d = sync_out;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Both operands are flop outputs reset to the same value, so the pulse is
  // glitch-free and drops to 0 as soon as n_rst asserts.
  always_comb begin
    edge_det = edge_detect(EDGE_MODE, sync_out, prev_q);
  end

endmodule

// File: tb/tb_sync_edge_det.sv
// Scoreboard bench for sync_edge_det across edge modes and synchronizer depths.
module tb_sync_edge_det;
  import sync_edge_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  logic async_in;
  logic det_rise, det_fall, det_both, det_s3, det_s4;

  always #5 clk = ~clk;

  sync_edge_det u_rise (.clk(clk), .n_rst(n_rst), .async_in(async_in), .edge_det(det_rise));
  sync_edge_det #(.EDGE_MODE(EDGE_FALL)) u_fall
    (.clk(clk), .n_rst(n_rst), .async_in(async_in), .edge_det(det_fall));
  sync_edge_det #(.EDGE_MODE(EDGE_BOTH)) u_both
    (.clk(clk), .n_rst(n_rst), .async_in(async_in), .edge_det(det_both));
  sync_edge_det #(.SYNC_STAGES(3)) u_s3
    (.clk(clk), .n_rst(n_rst), .async_in(async_in), .edge_det(det_s3));
  sync_edge_det #(.SYNC_STAGES(4)) u_s4
    (.clk(clk), .n_rst(n_rst), .async_in(async_in), .edge_det(det_s4));

  typedef struct packed {
    logic rise;
    logic fall;
    logic both;
    logic s3;
    logic s4;
  } exp_t;

  exp_t     sb[$];
  logic [7:0] hist;   // hist[i] = async_in as sampled i posedges ago
  int       n_chk;
  int       n_pass;
  int       cnt[5];   // rise, fall, both, s3, s4 pulse cycles seen

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rise"}, det_rise, 0);
    chk({tag, "_fall"}, det_fall, 0);
    chk({tag, "_both"}, det_both, 0);
    chk({tag, "_s3"},   det_s3,   0);
    chk({tag, "_s4"},   det_s4,   0);
  endtask

  // One clock: sample stimulus and push expectation at posedge, compare at negedge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (n_rst) begin
      hist   = {hist[6:0], async_in};
      e.rise = hist[1] & ~hist[2];
      e.fall = ~hist[1] & hist[2];
      e.both = hist[1] ^ hist[2];
      e.s3   = hist[2] & ~hist[3];
      e.s4   = hist[3] & ~hist[4];
      sb.push_back(e);
    end else begin
      sb.delete();
      hist = '0;
    end
    @(negedge clk);
    if (!n_rst) begin
      sb.delete();
      hist = '0;
      chk_all_zero("in_reset");
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_rise", det_rise, e.rise);
      chk("sb_fall", det_fall, e.fall);
      chk("sb_both", det_both, e.both);
      chk("sb_s3",   det_s3,   e.s3);
      chk("sb_s4",   det_s4,   e.s4);
    end
    cnt[0] += int'(det_rise);
    cnt[1] += int'(det_fall);
    cnt[2] += int'(det_both);
    cnt[3] += int'(det_s3);
    cnt[4] += int'(det_s4);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int c0[5];
    int on_r, on_b, on_3, on_4;
    int run, maxrun, first_b, second_b;

    n_chk = 0;
    n_pass = 0;
    cnt = '{default: 0};
    hist = '0;
    n_rst = 1'b0;
    async_in = 1'b0;

    ticks(3);
    n_rst = 1'b1;
    ticks(3);

    // One-cycle reset pulse on a negedge with input idle
    c0 = cnt;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    ticks(10);
    chk("idle_rise_pulses", cnt[0] - c0[0], 0);
    chk("idle_both_pulses", cnt[2] - c0[2], 0);

    // Rising edge: onset latency per depth, width 1
    c0 = cnt;
    on_r = 0; on_b = 0; on_3 = 0; on_4 = 0;
    async_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (det_rise && on_r == 0) on_r = i;
      if (det_both && on_b == 0) on_b = i;
      if (det_s3 && on_3 == 0) on_3 = i;
      if (det_s4 && on_4 == 0) on_4 = i;
    end
    chk("rise_onset", on_r, 2);
    chk("both_onset", on_b, 2);
    chk("s3_onset", on_3, 3);
    chk("s4_onset", on_4, 4);
    chk("rise_width", cnt[0] - c0[0], 1);
    chk("s3_width", cnt[3] - c0[3], 1);
    chk("s4_width", cnt[4] - c0[4], 1);
    chk("fall_on_rise", cnt[1] - c0[1], 0);

    // Falling edge
    c0 = cnt;
    async_in = 1'b0;
    ticks(8);
    chk("fall_width", cnt[1] - c0[1], 1);
    chk("rise_on_fall", cnt[0] - c0[0], 0);
    chk("both_on_fall", cnt[2] - c0[2], 1);

    // Both edges, 4 cycles apart
    c0 = cnt;
    first_b = 0; second_b = 0;
    async_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (det_both) begin
        if (first_b == 0) first_b = i;
        else if (second_b == 0) second_b = i;
      end
      if (i == 4) async_in = 1'b0;
    end
    chk("both_two_pulses", cnt[2] - c0[2], 2);
    chk("both_gap", second_b - first_b, 4);

    // Toggle every negedge for 8 cycles
    c0 = cnt;
    run = 0; maxrun = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) async_in = ~async_in;
      tick();
      if (det_both) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("toggle_both_run", maxrun, 8);
    chk("toggle_both_cnt", cnt[2] - c0[2], 8);
    chk("toggle_rise_cnt", cnt[0] - c0[0], 4);
    chk("toggle_fall_cnt", cnt[1] - c0[1], 4);
    chk("toggle_s4_cnt", cnt[4] - c0[4], 4);

    // Input already high across reset release
    n_rst = 1'b0;
    async_in = 1'b1;
    ticks(2);
    n_rst = 1'b1;
    c0 = cnt;
    on_r = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (det_rise && on_r == 0) on_r = i;
    end
    chk("rel_high_onset", on_r, 2);
    chk("rel_high_rise_cnt", cnt[0] - c0[0], 1);
    chk("rel_high_fall_cnt", cnt[1] - c0[1], 0);

    // Reset asserted while a pulse is high
    async_in = 1'b0;
    ticks(6);
    async_in = 1'b1;
    tick();
    @(posedge clk);
    #2;
    chk("pre_rst_rise", det_rise, 1);
    chk("pre_rst_both", det_both, 1);
    n_rst = 1'b0;
    #1;
    chk_all_zero("mid_pulse_rst");
    sb.delete();
    hist = '0;
    @(negedge clk);
    tick();
    n_rst = 1'b1;
    c0 = cnt;
    ticks(8);
    chk("post_rst_rise_cnt", cnt[0] - c0[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
